// File: rtl/key_scan.sv
// key_scan: 4x4 keypad scanner with frame debounce; define KEY_REPEAT_EN for auto-repeat
module key_scan #(
    parameter logic [15:0] SCAN_MAX        = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_FRAMES = 8'd5,
    parameter logic [7:0]  REPEAT_DELAY    = 8'd125,
    parameter logic [7:0]  REPEAT_RATE     = 8'd25
) (
    input  logic       key_clk,
    input  logic       key_rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    if (REPEAT_RATE == 8'd0 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
        $error("key_scan: REPEAT_RATE must be 1..REPEAT_DELAY");
    end

    logic [15:0] r_cnt;
    logic [1:0]  r_row_idx;
    logic [3:0]  r_row_out;
    logic [15:0] r_frame;
    logic        r_frame_done;
    state_t      r_state;
    logic [7:0]  r_db;
    logic [3:0]  r_cand;
    logic [3:0]  r_code;
    logic        r_valid;
    logic        r_down;

    logic        w_tick;
    logic [1:0]  w_row_nx;
    logic        w_none;
    logic        w_single;
    logic [3:0]  w_code;
    logic [7:0]  w_db_inc;
    state_t      w_state_nx;
    logic [7:0]  w_db_nx;
    logic [3:0]  w_cand_nx;
    logic [3:0]  w_code_nx;
    logic        w_valid_nx;
    logic        w_down_nx;

    assign w_tick   = r_cnt == SCAN_MAX - 16'd1;
    assign w_row_nx = r_row_idx + 2'd1;
    assign w_none   = r_frame == 16'd0;
    assign w_single = !w_none && ((r_frame & (r_frame - 16'd1)) == 16'd0);
    assign w_db_inc = r_db + 8'd1;

`ifdef KEY_REPEAT_EN
    logic [7:0] r_rep;
    logic [7:0] w_rep_nx;
    logic [7:0] w_rep_inc;
    assign w_rep_inc = r_rep + 8'd1;
`endif

    // Bit index of the lone closed key when the frame holds exactly one
    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 16; i++)
            if (r_frame[i]) w_code = 4'(i);
    end

    // Row rotation: each slot ends by latching that row's columns into the frame image
    always_ff @(posedge key_clk) begin
        if (key_rst) begin
            r_cnt        <= '0;
            r_row_idx    <= '0;
            r_row_out    <= 4'b1110;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? 16'd0 : r_cnt + 16'd1;
            r_frame_done <= w_tick && r_row_idx == 2'd3;
            if (w_tick) begin
                r_frame[{r_row_idx, 2'b00} +: 4] <= ~col_in;
                r_row_idx                        <= w_row_nx;
                r_row_out                        <= ~(4'b0001 << w_row_nx);
            end
        end
    end

    // Debounce FSM: evaluates one complete frame per frame_done pulse
    always_comb begin
        w_state_nx = r_state;
        w_db_nx    = r_db;
        w_cand_nx  = r_cand;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        w_down_nx  = r_down;
`ifdef KEY_REPEAT_EN
        w_rep_nx   = r_rep;
`endif
        if (r_frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_single && DEBOUNCE_FRAMES <= 8'd1) begin
                        w_state_nx = PRESSED;
                        w_code_nx  = w_code;
                        w_valid_nx = 1'b1;
                        w_down_nx  = 1'b1;
                    end else if (w_single) begin
                        w_state_nx = DEBOUNCE;
                        w_cand_nx  = w_code;
                        w_db_nx    = 8'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_single && w_code == r_cand && w_db_inc >= DEBOUNCE_FRAMES) begin
                        w_state_nx = PRESSED;
                        w_code_nx  = r_cand;
                        w_valid_nx = 1'b1;
                        w_down_nx  = 1'b1;
                        w_db_nx    = 8'd0;
                    end else if (w_single && w_code == r_cand) begin
                        w_db_nx    = w_db_inc;
                    end else begin
                        w_state_nx = IDLE;
                        w_db_nx    = 8'd0;
                    end
                end
                PRESSED: begin
                    if (w_none && DEBOUNCE_FRAMES <= 8'd1) begin
                        w_state_nx = IDLE;
                        w_down_nx  = 1'b0;
                        w_db_nx    = 8'd0;
`ifdef KEY_REPEAT_EN
                        w_rep_nx   = 8'd0;
`endif
                    end else if (w_none) begin
                        w_state_nx = RELEASE;
                        w_db_nx    = 8'd1;
                    end
`ifdef KEY_REPEAT_EN
                    else if (w_rep_inc >= REPEAT_DELAY) begin
                        w_valid_nx = 1'b1;
                        w_rep_nx   = REPEAT_DELAY - REPEAT_RATE;
                    end else begin
                        w_rep_nx   = w_rep_inc;
                    end
`endif
                end
                RELEASE: begin
                    if (w_none && w_db_inc >= DEBOUNCE_FRAMES) begin
                        w_state_nx = IDLE;
                        w_down_nx  = 1'b0;
                        w_db_nx    = 8'd0;
`ifdef KEY_REPEAT_EN
                        w_rep_nx   = 8'd0;
`endif
                    end else if (w_none) begin
                        w_db_nx    = w_db_inc;
                    end else begin
                        w_state_nx = PRESSED;
                        w_db_nx    = 8'd0;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // FSM state and report registers
    always_ff @(posedge key_clk) begin
        if (key_rst) begin
            r_state <= IDLE;
            r_db    <= '0;
            r_cand  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_db    <= w_db_nx;
            r_cand  <= w_cand_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
            r_down  <= w_down_nx;
`ifdef KEY_REPEAT_EN
            r_rep   <= w_rep_nx;
`endif
        end
    end

    assign row_out   = r_row_out;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = r_down;
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed keypad stimulus with a queue scoreboard on key_valid
module tb_key_scan;
    logic        key_clk = 1'b0;
    logic        key_rst = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys = 16'd0;
    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 key_clk = ~key_clk;

    key_scan #(
        .SCAN_MAX(16'd4),
        .DEBOUNCE_FRAMES(8'd3),
        .REPEAT_DELAY(8'd5),
        .REPEAT_RATE(8'd2)
    ) dut (
        .key_clk(key_clk),
        .key_rst(key_rst),
        .col_in(col_in),
        .row_out(row_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_down(key_down)
    );

    // Keypad: a closed key pulls its column low while its row is driven low
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    // Monitor: every key_valid must match the oldest expected report
    always @(negedge key_clk) begin
        if (key_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid got code=%0d required no report", key_code);
            end else begin
                automatic logic [3:0] e = exp_q.pop_front();
                if (key_code !== e) begin
                    n_errors++;
                    $display("FAIL valid_code got=%0d required=%0d", key_code, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic next_frame();
        logic [3:0] prev = row_out;
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge key_clk);
            if (row_out == 4'b1110 && prev != 4'b1110) found = 1;
            prev = row_out;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_timeout got=no frame start required=frame start within 64 cycles");
        end
    endtask

    task automatic frames(input int n);
        repeat (n) next_frame();
    endtask

    initial begin
        repeat (3) @(negedge key_clk);
        chk("rst_row", 16'(row_out), 16'hE);
        chk("rst_valid", 16'(key_valid), 16'h0);
        chk("rst_down", 16'(key_down), 16'h0);
        chk("rst_code", 16'(key_code), 16'h0);
        key_rst = 1'b0;
        repeat (3) @(negedge key_clk);
        chk("row0_hold", 16'(row_out), 16'hE);
        @(negedge key_clk);
        chk("row1", 16'(row_out), 16'hD);
        repeat (4) @(negedge key_clk);
        chk("row2", 16'(row_out), 16'hB);
        repeat (4) @(negedge key_clk);
        chk("row3", 16'(row_out), 16'h7);
        repeat (4) @(negedge key_clk);
        chk("row0_wrap", 16'(row_out), 16'hE);

        exp_q.push_back(4'd9);
        keys = 16'h0200;
        frames(3);
        chk("k9_down_early", 16'(key_down), 16'h0);
        @(negedge key_clk);
        chk("k9_down", 16'(key_down), 16'h1);
        chk("k9_code", 16'(key_code), 16'h9);
        frames(2);
        keys = 16'h0000;
        frames(3);
        chk("k9_release_early", 16'(key_down), 16'h1);
        @(negedge key_clk);
        chk("k9_release", 16'(key_down), 16'h0);

        frames(1);
        exp_q.push_back(4'd3);
        keys = 16'h0008;
        frames(2);
        keys = 16'h0000;
        frames(1);
        keys = 16'h0008;
        frames(3);
        chk("k3_down_early", 16'(key_down), 16'h0);
        @(negedge key_clk);
        chk("k3_down", 16'(key_down), 16'h1);
        chk("k3_code", 16'(key_code), 16'h3);
        keys = 16'h0000;
        frames(4);
        chk("k3_release", 16'(key_down), 16'h0);

        keys = 16'h0021;
        frames(4);
        chk("multi_down", 16'(key_down), 16'h0);
        exp_q.push_back(4'd5);
        keys = 16'h0020;
        frames(3);
        chk("k5_down_early", 16'(key_down), 16'h0);
        @(negedge key_clk);
        chk("k5_down", 16'(key_down), 16'h1);
        chk("k5_code", 16'(key_code), 16'h5);

        @(negedge key_clk);
        key_rst = 1'b1;
        keys = 16'h0000;
        @(negedge key_clk);
        key_rst = 1'b0;
        chk("midrst_down", 16'(key_down), 16'h0);
        chk("midrst_row", 16'(row_out), 16'hE);
        chk("midrst_valid", 16'(key_valid), 16'h0);

        frames(1);
        exp_q.push_back(4'd15);
`ifdef KEY_REPEAT_EN
        repeat (4) exp_q.push_back(4'd15);
`endif
        keys = 16'h8000;
        frames(14);
        @(negedge key_clk);
        keys = 16'h0000;
        frames(4);
        chk("k15_release", 16'(key_down), 16'h0);
        chk("k15_code", 16'(key_code), 16'hF);
        chk("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
